// File: rtl/dec2bcd_key_enc.sv
// Decimal key encoder: synchronizes and debounces ten raw key lines, then presents
// the highest pressed digit as BCD on a0..a3 (a0 = weight 8) through valid/ready,
// with a multi-key flag. Optional auto-repeat is enabled by defining KEYENC_REPEAT_EN.
module dec2bcd_key_enc #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 64,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] d,
  input  logic       ready,
  output logic       valid,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       multi
);

  // Handshake: a0..a3 and multi are held constant while valid=1 and ready=0;
  // one code is transferred on each rising edge where valid && ready.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("dec2bcd_key_enc: DEBOUNCE_CYCLES, REPEAT_CYCLES and CNT_W must be >= 1");
  end

  logic [9:0]       s1;
  logic [9:0]       s;
  logic [9:0]       s_prev;
  logic [9:0]       db;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_cnt_nxt;

  logic [3:0]       enc_code;
  logic [3:0]       ones;
  logic             enc_multi;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic [3:0]       code_q;
  logic             multi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s      <= '0;
      s_prev <= '0;
    end else begin
      s1     <= d;
      s      <= s1;
      s_prev <= s;
    end
  end

  // The counter value equals the number of extra equal samples seen; db takes s
  // on the edge the count becomes DEBOUNCE_CYCLES-1.
  always_comb begin
    if (s != s_prev)
      db_cnt_nxt = '0;
    else if (db_cnt != CNT_MAX)
      db_cnt_nxt = db_cnt + CNT_W'(1);
    else
      db_cnt_nxt = db_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      db     <= '0;
    end else begin
      db_cnt <= db_cnt_nxt;
      if (db_cnt_nxt == DB_LAST)
        db <= s;
    end
  end

  always_comb begin
    enc_code = 4'd0;
    ones     = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (db[i]) begin
        enc_code = 4'(i);
        ones     = ones + 4'd1;
      end
    end
  end

  assign enc_multi = (ones > 4'd1);

`ifdef KEYENC_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [9:0]       db_prev;
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_clr;
  logic             rpt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= '0;
      rpt_cnt <= '0;
    end else begin
      db_prev <= db;
      if (rpt_clr)
        rpt_cnt <= '0;
      else if (rpt_inc)
        rpt_cnt <= rpt_cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
`ifdef KEYENC_REPEAT_EN
    rpt_clr   = 1'b0;
    rpt_inc   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (db != '0) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (ready) begin
          state_nxt = WAIT_REL;
`ifdef KEYENC_REPEAT_EN
          rpt_clr   = 1'b1;
`endif
        end
      end
      WAIT_REL: begin
        // Any nonzero db here is the same press (or a lockout chord): no new code.
        if (db == '0) begin
          state_nxt = IDLE;
        end
`ifdef KEYENC_REPEAT_EN
        else if (db != db_prev) begin
          rpt_clr = 1'b1;
        end else if (rpt_cnt == RPT_LAST) begin
          load      = 1'b1;
          rpt_clr   = 1'b1;
          state_nxt = SEND;
        end else begin
          rpt_inc = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= 4'd0;
      multi_q <= 1'b0;
    end else if (load) begin
      code_q  <= enc_code;
      multi_q <= enc_multi;
    end
  end

  assign valid            = (state == SEND);
  assign {a0, a1, a2, a3} = code_q;
  assign multi            = multi_q;

endmodule

// File: tb/tb_dec2bcd_key_enc.sv
// Bench for dec2bcd_key_enc: directed key presses, expected {multi, a0..a3} queued
// by the driver and compared by an independent monitor on each transfer.
module tb_dec2bcd_key_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] d = '0;
  logic       ready = 1'b1;
  logic       valid;
  logic       a0, a1, a2, a3;
  logic       multi;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];

  dec2bcd_key_enc #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (16),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .ready(ready),
    .valid(valid),
    .a0   (a0),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .multi(multi)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every presented code against the queue head.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got code %b with nothing expected at %0t",
                 {multi, a0, a1, a2, a3}, $time);
      end else if (ready) begin
        check("transfer", {multi, a0, a1, a2, a3}, exp_q.pop_front());
      end else begin
        check("stall_hold", {multi, a0, a1, a2, a3}, exp_q[0]);
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Input was changed before the next edge k; valid must be low after k+5, high after k+6.
  task automatic check_latency(input string name);
    @(posedge clk);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      if (j == 5) check({name, "_early"}, 5'(valid), 5'd0);
      if (j == 6) check({name, "_valid"}, 5'(valid), 5'd1);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid === 1'b1) break;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL %s: valid not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    rst   = 1'b1;
    d     = '0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_valid", 5'(valid), 5'd0);
    check("reset_code", {1'b0, a0, a1, a2, a3}, 5'd0);
    check("reset_multi", 5'(multi), 5'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(10);

    // Digit 5 with exact latency, then release: exactly one emission.
    exp_q.push_back({1'b0, 4'd5});
    d = 10'b00_0010_0000;
    check_latency("lat_d5");
    step(5);
    d = '0;
    step(30);

    // Chord 9+3 -> 9 with multi; single keys 8 and 0.
    exp_q.push_back({1'b1, 4'd9});
    d = 10'b10_0000_1000;
    step(15);
    d = '0;
    step(15);
    exp_q.push_back({1'b0, 4'd8});
    d = 10'b01_0000_0000;
    step(15);
    d = '0;
    step(15);
    exp_q.push_back({1'b0, 4'd0});
    d = 10'b00_0000_0001;
    wait_valid("d0_valid", 30);
    step(10);
    d = '0;
    step(15);

    // Short glitches on digit 2 never emit; a solid hold does.
    repeat (8) begin
      d = 10'b00_0000_0100;
      step(2);
      d = '0;
      step(2);
    end
    step(10);
    exp_q.push_back({1'b0, 4'd2});
    d = 10'b00_0000_0100;
    check_latency("lat_d2");
    step(5);
    d = '0;
    step(15);

    // Stall with digit 7, switch to digit 4 while stalled, then accept.
    ready = 1'b0;
    exp_q.push_back({1'b0, 4'd7});
    d = 10'b00_1000_0000;
    wait_valid("d7_valid", 30);
    step(20);
    check("stall_valid", 5'(valid), 5'd1);
    d = 10'b00_0001_0000;
    step(15);
    check("stall_valid_after_switch", 5'(valid), 5'd1);
    check("stall_code_after_switch", {multi, a0, a1, a2, a3}, {1'b0, 4'd7});
    ready = 1'b1;
    step(25);
    check("lockout_no_valid", 5'(valid), 5'd0);
    d = '0;
    step(15);
    exp_q.push_back({1'b0, 4'd4});
    d = 10'b00_0001_0000;
    step(15);
    d = '0;
    step(15);

    // Reset while digit 6 is pending drops it; the held key re-emits after release.
    ready = 1'b0;
    exp_q.push_back({1'b0, 4'd6});
    d = 10'b00_0100_0000;
    wait_valid("d6_valid", 30);
    step(3);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 5'(valid), 5'd0);
    check("midrst_code", {multi, a0, a1, a2, a3}, 5'd0);
    exp_q.delete();
    step(3);
    rst   = 1'b0;
    ready = 1'b1;
    exp_q.push_back({1'b0, 4'd6});
    check_latency("lat_after_rst");
    step(5);
    d = '0;
    step(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: got %0d codes never presented, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec2bcd_key_enc.md
Name: dec2bcd_key_enc

Overview:
- Decimal-to-BCD encoder: the input end feeding the team's 1-of-10 BCD-to-decimal decoder.
- Takes 10 raw, asynchronous, active-high decimal key lines d[9:0] (bit n = digit n) and synchronizes and debounces them.
- Priority-encodes the pressed digit to 4-bit BCD on a0..a3, with a0 = weight 8 and a3 = weight 1, so it wires directly to the decoder's a0..a3 inputs.
- Presents each press once through a valid/ready handshake, with a multi-key flag.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required before the debounced vector updates (>=1).
REPEAT_CYCLES, 64, hold time in cycles before auto-repeat re-emits (used only with the optional feature, >=1).
CNT_W, 16, width of the internal debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES).

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous active-high reset
d  input  10  raw decimal key lines, async to clk, active-high, d[n] = digit n
ready  input  1  consumer accepts the code when high together with valid
valid  output  1  a0..a3 and multi hold a new code
a0  output  1  BCD bit weight 8 (MSB)
a1  output  1  BCD bit weight 4
a2  output  1  BCD bit weight 2
a3  output  1  BCD bit weight 1 (LSB)
multi  output  1  more than one key was down when the code was latched

Behaviour:
- Reset is asynchronous and active-high: clk is the only clock; rst asserts immediately and releases synchronously.
- Reset values: valid=0, a0..a3=0, multi=0, synchronizer=0, debounced vector db=0, counters=0, FSM=IDLE.
- Synchronizer: 2 flops on all 10 lines; the stage-2 output is s.
- Debounce:
  - If s != previous s, the counter is cleared.
  - Otherwise the counter increments, saturating.
  - db loads s on the cycle the count reaches DEBOUNCE_CYCLES-1, so s must be equal for DEBOUNCE_CYCLES consecutive samples.
- Encode:
  - Code = index of the highest set bit of db; ties resolve upward (d9 wins).
  - multi = 1 when popcount(db) > 1.
  - The code is 0..9 only; 10..15 are never produced.
- FSM:
  - IDLE: when db != 0, latch code and multi into the output registers and go to SEND; valid=1 from the next edge.
  - SEND: valid=1. a0..a3 and multi are stable and must not change while valid=1 and ready=0. On valid&&ready at a rising edge, go to WAIT_REL; valid=0 after that edge.
  - WAIT_REL: valid=0 and outputs hold the last code. When db==0, go to IDLE.
- Lockout: a change of db to a different nonzero value in SEND or WAIT_REL emits nothing. A new code needs all keys released (db==0) first.
- Latency: a clean input change before edge k gives valid=1 after edge k+DEBOUNCE_CYCLES+2. With the default of 4, valid rises after edge k+6 (7 edges inclusive).
- Release while in SEND: the code stays presented until accepted, then the FSM returns to IDLE via WAIT_REL.
- Glitches shorter than DEBOUNCE_CYCLES samples never reach db and never cause valid.
- ready is ignored when valid=0.
- Reset mid-handshake drops the pending code with no emission. After release, a key already held is seen as a new press after the normal latency.

Optional Feature:
- Macro name: KEYENC_REPEAT_EN.
- When defined: in WAIT_REL, while db is nonzero and unchanged, a repeat counter increments. Reaching REPEAT_CYCLES-1 re-latches code/multi from db, clears the counter and enters SEND. The counter clears whenever db changes or on each entry to WAIT_REL.
- When undefined: no repeat counter exists, and exactly one emission occurs per press.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, ready=1, hold d=10'b0000100000 (digit 5) -> valid pulses 1 cycle after 7 edges; a0..a3=0101, multi=0. Release and wait -> no second valid.
- Hold d[9] and d[3] together -> a0..a3=1001, multi=1. Hold d[8] alone -> 1000, multi=0. Hold d[0] alone -> 0000, valid=1.
- Toggle d[2] for 2-cycle pulses repeatedly -> valid never asserts. Then hold d[2] -> code 0010 after the full latency.
- ready=0 for 20 cycles with digit 7 held -> valid stays 1 and a0..a3=0111 stable. Switch the key to digit 4 while stalled -> outputs remain 0111. ready=1 -> one transfer of 0111, then 0100 appears only after full release and a new press.
- Assert rst in SEND with digit 6 pending -> valid=0 and outputs=0 immediately. Release rst with the key still held -> 0110 emitted after full latency.
- With KEYENC_REPEAT_EN, REPEAT_CYCLES=16, ready=1, digit 3 held 100 cycles -> initial 0011, then a repeat every 17 cycles. Without the macro -> a single 0011.
